// File: rtl/vec_lane_array.sv
// Multi-cycle vector execution unit: strip-mines a VLEN-element vector over LANES lanes,
// one pass per clock, with per-element masking, saturating add, flush and valid/ready handshakes.
module vec_lane_array #(
  parameter int LANES  = 4,
  parameter int ELEM_W = 8,
  parameter int VLEN   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_op,
  input  logic [ELEM_W-1:0]          in_imm,
  input  logic [$clog2(ELEM_W)-1:0]  in_shamt,
  input  logic [VLEN*ELEM_W-1:0]     in_vs,
  input  logic [VLEN*ELEM_W-1:0]     in_vt,
  input  logic [VLEN*ELEM_W-1:0]     in_vd,
  input  logic [VLEN-1:0]            in_mask,
  input  logic [4:0]                 in_dst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [VLEN*ELEM_W-1:0]     out_data,
  output logic [4:0]                 out_dst,
  output logic                       out_illegal,
  output logic                       busy
);

  localparam int PASSES = VLEN / LANES;
  localparam int SHW    = $clog2(ELEM_W);
  localparam int VW     = VLEN * ELEM_W;
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       pass_q, pass_d;
  logic [VW-1:0]       work_q, work_d;
  logic [VW-1:0]       outData_q, outData_d;
  logic                outIllegal_q, outIllegal_d;
  logic [3:0]          op_q;
  logic [ELEM_W-1:0]   imm_q;
  logic [SHW-1:0]      shamt_q;
  logic [VW-1:0]       vs_q, vt_q, vd_q;
  logic [VLEN-1:0]     mask_q;
  logic [4:0]          dst_q;
  logic                accept;
  logic                opIllegal;

  logic [LANES-1:0][ELEM_W-1:0] laneA, laneB, laneVd, laneRes;
  logic [LANES-1:0]             laneMask;

  function automatic logic [ELEM_W-1:0] elemOp(
    input logic [3:0]        op,
    input logic [ELEM_W-1:0] a,
    input logic [ELEM_W-1:0] b,
    input logic [ELEM_W-1:0] imm,
    input logic [SHW-1:0]    sh
  );
    logic [ELEM_W:0]   sum;
    logic [ELEM_W-1:0] r;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      4'd0:    r = sum[ELEM_W-1:0];
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = a << sh;
      4'd6:    r = a >> sh;
      4'd7:    r = a + imm;
      4'd8:    r = sum[ELEM_W] ? {ELEM_W{1'b1}} : sum[ELEM_W-1:0];
      default: r = a;
    endcase
    return r;
  endfunction

  assign opIllegal   = (op_q > 4'd8);
  assign accept      = in_valid && in_ready;
  assign out_data    = outData_q;
  assign out_dst     = dst_q;
  assign out_illegal = outIllegal_q;

  // Each lane picks the element of the current pass, so only LANES ALUs exist
  always_comb begin
    laneA    = '0;
    laneB    = '0;
    laneVd   = '0;
    laneMask = '0;
    laneRes  = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int p = 0; p < PASSES; p++) begin
        if (pass_q == PW'(p)) begin
          laneA[l]    = vs_q[(p*LANES+l)*ELEM_W +: ELEM_W];
          laneB[l]    = vt_q[(p*LANES+l)*ELEM_W +: ELEM_W];
          laneVd[l]   = vd_q[(p*LANES+l)*ELEM_W +: ELEM_W];
          laneMask[l] = mask_q[p*LANES+l];
        end
      end
      laneRes[l] = (opIllegal || !laneMask[l]) ? laneVd[l]
                 : elemOp(op_q, laneA[l], laneB[l], imm_q, shamt_q);
    end
  end

  always_comb begin
    state_d      = state_q;
    pass_d       = pass_q;
    work_d       = work_q;
    outData_d    = outData_q;
    outIllegal_d = outIllegal_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !flush;
        if (in_valid && !flush) begin
          state_d = EXEC;
          pass_d  = '0;
        end
      end
      EXEC: begin
        busy = 1'b1;
        for (int l = 0; l < LANES; l++) begin
          for (int p = 0; p < PASSES; p++) begin
            if (pass_q == PW'(p)) begin
              work_d[(p*LANES+l)*ELEM_W +: ELEM_W] = laneRes[l];
            end
          end
        end
        if (pass_q == LAST_PASS) begin
          state_d      = DONE;
          pass_d       = '0;
          outData_d    = work_d;
          outIllegal_d = opIllegal;
        end else begin
          pass_d = pass_q + PW'(1);
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d      = IDLE;
          outIllegal_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush overrides any handshake in the same cycle; the visible result is left alone
    if (flush) begin
      state_d      = IDLE;
      pass_d       = '0;
      outIllegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pass_q       <= '0;
      work_q       <= '0;
      outData_q    <= '0;
      outIllegal_q <= 1'b0;
      op_q         <= '0;
      imm_q        <= '0;
      shamt_q      <= '0;
      vs_q         <= '0;
      vt_q         <= '0;
      vd_q         <= '0;
      mask_q       <= '0;
      dst_q        <= '0;
    end else begin
      state_q      <= state_d;
      pass_q       <= pass_d;
      work_q       <= work_d;
      outData_q    <= outData_d;
      outIllegal_q <= outIllegal_d;
      if (accept) begin
        op_q    <= in_op;
        imm_q   <= in_imm;
        shamt_q <= in_shamt;
        vs_q    <= in_vs;
        vt_q    <= in_vt;
        vd_q    <= in_vd;
        mask_q  <= in_mask;
        dst_q   <= in_dst;
      end
    end
  end

endmodule

// File: tb/tb_vec_lane_array.sv
// Bench for vec_lane_array: a whole-vector reference model checked every cycle, plus
// directed operations with literal expectations and a wide-lane instance.
module tb_vec_lane_array;

  localparam int PASSES = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  in_op = '0;
  logic [7:0]  in_imm = '0;
  logic [2:0]  in_shamt = '0;
  logic [63:0] in_vs = '0, in_vt = '0, in_vd = '0;
  logic [7:0]  in_mask = '0;
  logic [4:0]  in_dst = '0;
  logic        in_ready, out_valid, out_illegal, busy;
  logic [63:0] out_data;
  logic [4:0]  out_dst;

  logic         wValid = 1'b0;
  logic         wOutReady = 1'b0;
  logic [3:0]   wOp = '0;
  logic [15:0]  wImm = '0;
  logic [3:0]   wShamt = '0;
  logic [127:0] wVs = '0, wVt = '0, wVd = '0;
  logic [7:0]   wMask = '0;
  logic [4:0]   wDst = '0;
  logic         wInReady, wOutValid, wOutIllegal, wBusy;
  logic [127:0] wOutData;
  logic [4:0]   wOutDst;

  int checks = 0;
  int failures = 0;

  logic        mBusy = 1'b0, mValid = 1'b0, mIll = 1'b0, mPendIll = 1'b0;
  logic [63:0] mData = '0, mPend = '0;
  logic [4:0]  mDst = '0;
  int          mCount = 0;

  vec_lane_array dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_imm(in_imm), .in_shamt(in_shamt), .in_vs(in_vs), .in_vt(in_vt),
    .in_vd(in_vd), .in_mask(in_mask), .in_dst(in_dst), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_dst(out_dst),
    .out_illegal(out_illegal), .busy(busy)
  );

  vec_lane_array #(.LANES(8), .ELEM_W(16), .VLEN(8)) wideDut (
    .clk(clk), .reset(reset), .flush(1'b0), .in_valid(wValid), .in_ready(wInReady),
    .in_op(wOp), .in_imm(wImm), .in_shamt(wShamt), .in_vs(wVs), .in_vt(wVt),
    .in_vd(wVd), .in_mask(wMask), .in_dst(wDst), .out_valid(wOutValid),
    .out_ready(wOutReady), .out_data(wOutData), .out_dst(wOutDst),
    .out_illegal(wOutIllegal), .busy(wBusy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Whole-vector result computed from the operation table with plain integer arithmetic
  function automatic logic [63:0] modelVec(input logic [3:0] op, input logic [7:0] imm,
                                           input logic [2:0] sh, input logic [63:0] vs,
                                           input logic [63:0] vt, input logic [63:0] vd,
                                           input logic [7:0] mask);
    logic [63:0] res;
    int a, b, d, r;
    res = '0;
    for (int e = 0; e < 8; e++) begin
      a = int'(vs[e*8 +: 8]);
      b = int'(vt[e*8 +: 8]);
      d = int'(vd[e*8 +: 8]);
      case (op)
        4'd0: r = a + b;
        4'd1: r = a - b;
        4'd2: r = a & b;
        4'd3: r = a | b;
        4'd4: r = a ^ b;
        4'd5: r = a << sh;
        4'd6: r = a >> sh;
        4'd7: r = a + int'(imm);
        4'd8: r = (a + b > 255) ? 255 : a + b;
        default: r = d;
      endcase
      if (!mask[e]) r = d;
      res[e*8 +: 8] = r[7:0];
    end
    return res;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mBusy <= 1'b0; mValid <= 1'b0; mIll <= 1'b0; mData <= '0; mDst <= '0; mCount <= 0;
    end else if (flush) begin
      mBusy <= 1'b0; mValid <= 1'b0; mIll <= 1'b0;
    end else if (!mBusy) begin
      if (in_valid) begin
        mBusy    <= 1'b1;
        mCount   <= PASSES;
        mPend    <= modelVec(in_op, in_imm, in_shamt, in_vs, in_vt, in_vd, in_mask);
        mPendIll <= (in_op > 4'd8);
        mDst     <= in_dst;
      end
    end else if (mValid) begin
      if (out_ready) begin
        mValid <= 1'b0; mBusy <= 1'b0; mIll <= 1'b0;
      end
    end else begin
      mCount <= mCount - 1;
      if (mCount == 1) begin
        mValid <= 1'b1; mData <= mPend; mIll <= mPendIll;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    checkOutput("mdl_in_ready", in_ready, !mBusy && !flush);
    checkOutput("mdl_busy", busy, mBusy);
    checkOutput("mdl_out_valid", out_valid, mValid);
    checkOutput("mdl_out_illegal", out_illegal, mIll);
    checkOutput("mdl_out_dst", out_dst, mDst);
    checkOutput("mdl_out_data", out_data, mData);
  end

  // Called at a negedge; the op is accepted on the next posedge, returns at the following negedge
  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] imm, input logic [2:0] sh,
                               input logic [63:0] vs, input logic [63:0] vt,
                               input logic [63:0] vd, input logic [7:0] mask,
                               input logic [4:0] dst);
    in_op = op; in_imm = imm; in_shamt = sh; in_vs = vs; in_vt = vt; in_vd = vd;
    in_mask = mask; in_dst = dst; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("accepted_busy", busy, 1'b1);
  endtask

  task automatic waitValid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    if (!out_valid) checkOutput("wait_valid_timeout", 1'b0, 1'b1);
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_out_data", out_data, 64'h0);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] wide lanes, single pass ADD");
    wOp = 4'd0; wMask = 8'hFF; wDst = 5'd2;
    wVs = {{7{16'h1234}}, 16'hFFFF};
    wVt = {{7{16'h0F0F}}, 16'h0002};
    wVd = '0;
    wValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wValid = 1'b0;
    lat = 0;
    while (!wOutValid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("wide_latency", lat, 1);
    checkOutput("wide_data", wOutData, {{7{16'h2143}}, 16'h0001});
    checkOutput("wide_dst", wOutDst, 5'd2);
    wOutReady = 1'b1;
    @(negedge clk);
    wOutReady = 1'b0;
    checkOutput("wide_released", wOutValid, 1'b0);

    $display("[TB] ADD with wrap");
    applyStimulus(4'd0, 8'h00, 3'd0, {8{8'hF0}}, {8{8'h20}}, {8{8'h55}}, 8'hFF, 5'd3);
    checkOutput("add_in_ready_exec", in_ready, 1'b0);
    waitValid(lat);
    checkOutput("add_latency", lat, PASSES);
    checkOutput("add_data", out_data, {8{8'h10}});
    checkOutput("add_illegal", out_illegal, 1'b0);
    checkOutput("add_in_ready_done", in_ready, 1'b0);
    handoff();

    applyStimulus(4'd8, 8'h00, 3'd0, {8{8'hF0}}, {8{8'h20}}, {8{8'h55}}, 8'hFF, 5'd4);
    waitValid(lat);
    checkOutput("satadd_data", out_data, {8{8'hFF}});
    handoff();

    applyStimulus(4'd5, 8'h00, 3'd1, {8{8'h81}}, '0, '0, 8'hFF, 5'd5);
    waitValid(lat);
    checkOutput("sll_data", out_data, {8{8'h02}});
    handoff();

    applyStimulus(4'd6, 8'h00, 3'd7, {8{8'h81}}, '0, '0, 8'hFF, 5'd6);
    waitValid(lat);
    checkOutput("srl_data", out_data, {8{8'h01}});
    handoff();

    applyStimulus(4'd7, 8'h05, 3'd0, {8{8'h10}}, '0, '0, 8'hF0, 5'd1);
    waitValid(lat);
    checkOutput("addi_masked_data", out_data, 64'h1515151500000000);
    handoff();

    $display("[TB] masked SUB with stalled consumer");
    applyStimulus(4'd1, 8'h00, 3'd0, {8{8'h05}}, {8{8'h03}}, {8{8'hAA}}, 8'h0F, 5'd9);
    waitValid(lat);
    repeat (5) @(negedge clk);
    checkOutput("stall_valid", out_valid, 1'b1);
    checkOutput("stall_in_ready", in_ready, 1'b0);
    checkOutput("stall_data", out_data, 64'hAAAAAAAA02020202);
    checkOutput("stall_dst", out_dst, 5'd9);
    handoff();
    checkOutput("handoff_valid", out_valid, 1'b0);
    checkOutput("handoff_in_ready", in_ready, 1'b1);
    applyStimulus(4'd4, 8'h00, 3'd0, {8{8'h0F}}, {8{8'hFF}}, '0, 8'hFF, 5'd10);
    waitValid(lat);
    checkOutput("xor_data", out_data, {8{8'hF0}});
    checkOutput("xor_dst", out_dst, 5'd10);
    handoff();

    $display("[TB] flush cases");
    applyStimulus(4'd3, 8'h00, 3'd0, {8{8'h0F}}, {8{8'hF0}}, '0, 8'hFF, 5'd11);
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_exec_busy", busy, 1'b0);
    flush = 1'b0;
    #1;
    checkOutput("flush_exec_in_ready", in_ready, 1'b1);
    repeat (4) begin
      @(negedge clk);
      checkOutput("flush_no_valid", out_valid, 1'b0);
    end
    in_op = 4'd0; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_idle_blocks", busy, 1'b0);
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    applyStimulus(4'd3, 8'h00, 3'd0, {8{8'h0F}}, {8{8'hF0}}, '0, 8'hFF, 5'd12);
    waitValid(lat);
    checkOutput("or_data", out_data, {8{8'hFF}});
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    checkOutput("flush_done_valid", out_valid, 1'b0);
    checkOutput("flush_done_busy", busy, 1'b0);

    $display("[TB] reset while holding a result");
    applyStimulus(4'd2, 8'h00, 3'd0, {8{8'h3C}}, {8{8'h0F}}, '0, 8'hFF, 5'd7);
    waitValid(lat);
    checkOutput("and_data", out_data, {8{8'h0C}});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_done_data", out_data, 64'h0);
    checkOutput("rst_done_dst", out_dst, 5'd0);
    checkOutput("rst_done_valid", out_valid, 1'b0);
    checkOutput("rst_done_illegal", out_illegal, 1'b0);
    checkOutput("rst_done_busy", busy, 1'b0);
    checkOutput("rst_done_in_ready", in_ready, 1'b1);

    $display("[TB] illegal opcode");
    applyStimulus(4'hC, 8'h00, 3'd0, {8{8'h11}}, {8{8'h22}}, 64'h0123456789ABCDEF, 8'h3C, 5'd13);
    waitValid(lat);
    checkOutput("illegal_latency", lat, PASSES);
    checkOutput("illegal_data", out_data, 64'h0123456789ABCDEF);
    checkOutput("illegal_flag", out_illegal, 1'b1);
    handoff();
    checkOutput("illegal_cleared", out_illegal, 1'b0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
